// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared constants and types for the cacheline <-> memory burst adapter.
package cacheline_burst_adapter_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  localparam int LSB_W    = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} adapter_state_t;

  // Clear the in-line byte offset so memory always sees a line-aligned address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side and memory-side signals of the burst adapter, bundled as one bus.
// slave = the adapter's view, master = the cache/memory environment's view.
interface cacheline_burst_adapter_if;
  import cacheline_burst_adapter_pkg::*;

  // cache side
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  // memory side
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one 256-bit cacheline fill/writeback into a 4 x 64-bit memory burst.
// Fill beats are assembled into rbuf (which drives line_o); writeback data is
// held in a separate wbuf so a writeback never disturbs the last filled line.
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_burst_adapter_if.slave bus
);

  adapter_state_t    state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_d;
  logic [LINE_W-1:0] rbuf_q;
  logic [LINE_W-1:0] wbuf_q;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;
  logic              write_q;
  logic              resp_q;
  logic              last_beat;
  logic [LSB_W-1:0]  beat_lsb;

  // Counter wraps naturally to 0 after the last beat (BEATS is a power of two).
  assign beat_cnt_d = beat_cnt_q + 1'b1;
  assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign beat_lsb   = {beat_cnt_q, {(LSB_W - CNT_W){1'b0}}};

  // Transfer FSM: request latch, beat counting, buffer fill and registered bus controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rbuf_q     <= '0;
      wbuf_q     <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // write wins if both are raised; resp_i is ignored here
          if (bus.write_i) begin
            wbuf_q  <= bus.line_i;
            addr_q  <= line_align(bus.address_i);
            write_q <= 1'b1;
            state_q <= WR_BURST;
          end else if (bus.read_i) begin
            addr_q  <= line_align(bus.address_i);
            read_q  <= 1'b1;
            state_q <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bus.resp_i) begin
            rbuf_q[beat_lsb +: BEAT_W] <= bus.burst_i;
            beat_cnt_q                 <= beat_cnt_d;
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (bus.resp_i) begin
            beat_cnt_q <= beat_cnt_d;
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write beat is selected straight from the registered count; quiet outside a writeback.
  assign bus.burst_o   = write_q ? wbuf_q[beat_lsb +: BEAT_W] : '0;
  assign bus.line_o    = rbuf_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: stimulus pushes expected write
// beats and completions; a negedge monitor pops and compares them.
module tb_cacheline_burst_adapter;
  import cacheline_burst_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adapter_if bus();

  cacheline_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              is_rd;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr;
  } done_t;

  done_t       exp_done[$];
  logic [63:0] exp_wbeat[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expectations whenever the DUT presents a beat or completion
  always @(negedge clk) begin
    done_t e;
    if (!rst) begin
      chk("rd_wr_exclusive", LINE_W'(bus.read_o & bus.write_o), '0);
      if (bus.write_o && bus.resp_i) begin
        chk("wbeat_expected", LINE_W'(exp_wbeat.size() != 0), LINE_W'(1));
        if (exp_wbeat.size() != 0) chk("burst_o", LINE_W'(bus.burst_o), LINE_W'(exp_wbeat.pop_front()));
      end
      if (bus.resp_o) begin
        chk("resp_o_expected", LINE_W'(exp_done.size() != 0), LINE_W'(1));
        if (exp_done.size() != 0) begin
          e = exp_done.pop_front();
          chk("done_address_o", LINE_W'(bus.address_o), LINE_W'(e.addr));
          chk("done_write_idle", LINE_W'(bus.read_o | bus.write_o), '0);
          if (e.is_rd) chk("line_o", bus.line_o, e.line);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_done.size() != 0 || exp_wbeat.size() != 0) && k < 20) begin
      cyc();
      k++;
    end
    chk({nm, "_drained"}, LINE_W'(exp_done.size() + exp_wbeat.size()), '0);
  endtask

  // Fill: pat bit i (LSB first) = resp_i in beat-phase cycle i
  task automatic fill(input string nm, input logic [31:0] a, input logic [31:0] a_exp,
                      input logic [3:0][63:0] b, input logic [LINE_W-1:0] line_exp,
                      input logic [15:0] pat, input int plen);
    int bi = 0;
    bus.address_i = a;
    bus.read_i    = 1'b1;
    cyc();
    bus.read_i    = 1'b0;
    bus.address_i = 32'hFFFF_FFFF;
    chk({nm, "_addr_accept"}, LINE_W'(bus.address_o), LINE_W'(a_exp));
    exp_done.push_back('{1'b1, line_exp, a_exp});
    for (int i = 0; i < plen; i++) begin
      chk({nm, "_read_o_held"}, LINE_W'({bus.read_o, bus.write_o}), LINE_W'(2'b10));
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? b[bi] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[i]) bi++;
      cyc();
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    chk({nm, "_resp_after_last"}, LINE_W'({bus.resp_o, bus.read_o}), LINE_W'(2'b10));
    drain(nm);
  endtask

  task automatic wb(input string nm, input logic [31:0] a, input logic [31:0] a_exp,
                    input logic [LINE_W-1:0] ln, input logic [3:0][63:0] bexp, input logic also_rd);
    bus.address_i = a;
    bus.line_i    = ln;
    bus.write_i   = 1'b1;
    bus.read_i    = also_rd;
    cyc();
    bus.write_i   = 1'b0;
    bus.read_i    = 1'b0;
    bus.line_i    = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    chk({nm, "_addr_accept"}, LINE_W'(bus.address_o), LINE_W'(a_exp));
    for (int i = 0; i < 4; i++) exp_wbeat.push_back(bexp[i]);
    exp_done.push_back('{1'b0, '0, a_exp});
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_write_o_held"}, LINE_W'({bus.read_o, bus.write_o}), LINE_W'(2'b01));
      bus.resp_i = 1'b1;
      cyc();
    end
    bus.resp_i = 1'b0;
    chk({nm, "_resp_after_last"}, LINE_W'({bus.resp_o, bus.write_o, bus.read_o}), LINE_W'(3'b100));
    drain(nm);
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] WB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] WC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] WD = 64'hDDDD_0000_0000_000D;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] l1, l2, l3;
    l1 = {B4, B3, B2, B1};
    l2 = {64'h8888_8888_0000_0008, 64'h7777_7777_0000_0007, 64'h6666_6666_0000_0006, 64'h5555_5555_0000_0005};
    l3 = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    rst = 1'b1;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    #12;
    chk("reset_ctrl", LINE_W'({bus.read_o, bus.write_o, bus.resp_o}), '0);
    chk("reset_address_o", LINE_W'(bus.address_o), '0);
    chk("reset_line_o", bus.line_o, '0);
    chk("reset_burst_o", LINE_W'(bus.burst_o), '0);
    cyc();
    rst = 1'b0;
    cyc();

    // basic fill
    fill("fill", 32'h0000_1234, 32'h0000_1220, {B4, B3, B2, B1}, l1, 16'h000F, 4);

    // writeback, then line_o must still show the fill
    wb("wb", 32'hDEAD_BEEF, 32'hDEAD_BEE0, {WD, WC, WB, WA}, {WD, WC, WB, WA}, 1'b0);
    chk("line_o_after_wb", bus.line_o, l1);

    // stalled beats 1,0,0,1,1,0,1
    fill("stall", 32'h0000_2040, 32'h0000_2040, l2, l2, 16'b1011001, 7);

    // reset after two read beats
    bus.address_i = 32'h0000_0047; bus.read_i = 1'b1;
    cyc();
    bus.read_i = 1'b0;
    bus.resp_i = 1'b1; bus.burst_i = 64'hEEEE_0000_0000_0001;
    cyc();
    bus.burst_i = 64'hEEEE_0000_0000_0002;
    cyc();
    bus.resp_i = 1'b0;
    chk("pre_reset_read_o", LINE_W'(bus.read_o), LINE_W'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", LINE_W'({bus.read_o, bus.write_o, bus.resp_o}), '0);
    chk("rst_mid_line_o", bus.line_o, '0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset_quiet", LINE_W'({bus.read_o, bus.write_o, bus.resp_o}), '0);
    end
    fill("fill_after_rst", 32'h0000_1234, 32'h0000_1220, {B4, B3, B2, B1}, l1, 16'h000F, 4);

    // spurious resp_i in IDLE, then simultaneous read&write
    bus.resp_i = 1'b1; bus.burst_i = 64'hF00D_F00D_F00D_F00D;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("idle_resp_ignored", LINE_W'({bus.read_o, bus.write_o, bus.resp_o}), '0);
    end
    bus.resp_i = 1'b0;
    wb("wb_rdwr", 32'h1000_003F, 32'h1000_0020, {WA, WB, WC, WD}, {WA, WB, WC, WD}, 1'b1);
    chk("line_o_after_wb2", bus.line_o, l1);

    // back-to-back: read held one cycle past resp_o
    bus.address_i = 32'h0000_3000; bus.read_i = 1'b1;
    cyc();
    exp_done.push_back('{1'b1, l2, 32'h0000_3000});
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1; bus.burst_i = l2[i*64 +: 64];
      cyc();
    end
    bus.resp_i = 1'b0;
    bus.address_i = 32'h0000_4010;
    chk("b2b_first_resp", LINE_W'(bus.resp_o), LINE_W'(1));
    cyc();                       // DONE -> IDLE, read_i still high
    cyc();                       // IDLE accept of second fill
    bus.read_i = 1'b0;
    chk("b2b_second_accept", LINE_W'({bus.read_o, bus.address_o}), LINE_W'({1'b1, 32'h0000_4000}));
    exp_done.push_back('{1'b1, l3, 32'h0000_4000});
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1; bus.burst_i = l3[i*64 +: 64];
      cyc();
    end
    bus.resp_i = 1'b0;
    chk("b2b_second_resp", LINE_W'(bus.resp_o), LINE_W'(1));
    drain("b2b");
    cyc();
    chk("b2b_idle", LINE_W'({bus.read_o, bus.write_o, bus.resp_o}), '0);
    chk("b2b_line_held", bus.line_o, l3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
